// File: rtl/io_display_unit.sv
// I/O display unit: input snapshot register, sticky error flag, and a signed binary-to-BCD
// display converter. Define IO_DISPLAY_BLANK_EN to blank leading zero digits and the positive sign.
module io_display_unit #(
    parameter int N_IN   = 7,
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_IN*WIDTH-1:0] indata,
    input  logic                  sample,
    output logic [N_IN*WIDTH-1:0] indata_q,
    input  logic [WIDTH-1:0]      result,
    input  logic                  result_valid,
    input  logic                  overflow_in,
    input  logic                  stack_error_in,
    input  logic                  error_clear,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [3:0]            seg_sign,
    output logic [4*DIGITS-1:0]   seg_digits
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q;
    logic                  sign_q;
    logic [WIDTH-1:0]      mag_q;
    logic [4*DIGITS-1:0]   bcd_q, bcd_adj, bcd_shift;
    logic                  done_q;
    logic                  error_q, error_d, cause;
    logic [3:0]            seg_sign_q, disp_sign;
    logic [4*DIGITS-1:0]   seg_digits_q, disp;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (result_valid) state_d = S_SHIFT;
            S_SHIFT: if (cnt_q == LAST) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy       = (state_q != S_IDLE);
        done       = done_q;
        error      = error_q;
        seg_sign   = seg_sign_q;
        seg_digits = seg_digits_q;
    end

    always_comb begin
        cause = overflow_in | stack_error_in;
        for (int k = 0; k < N_IN; k++)
            cause = cause | indata_q[k*WIDTH + WIDTH - 1];
    end

    // A new cause outranks a same-cycle clear
    assign error_d = cause | (error_q & ~error_clear);

    // Double-dabble step: add 3 to every nibble >= 5, then shift in the next magnitude bit
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++)
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    assign bcd_shift = {bcd_adj[4*DIGITS-2:0], mag_q[WIDTH-1]};

    always_comb begin
        disp      = bcd_q;
        disp_sign = sign_q ? 4'hF : 4'h0;
`ifdef IO_DISPLAY_BLANK_EN
        begin
            logic lead;
            lead = 1'b1;
            for (int i = DIGITS - 1; i >= 1; i--) begin
                if (bcd_q[4*i +: 4] != 4'd0) lead = 1'b0;
                if (lead) disp[4*i +: 4] = 4'hA;
            end
            if (!sign_q) disp_sign = 4'hA;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            indata_q     <= '0;
            error_q      <= 1'b0;
            cnt_q        <= '0;
            sign_q       <= 1'b0;
            mag_q        <= '0;
            bcd_q        <= '0;
            done_q       <= 1'b0;
            seg_sign_q   <= 4'h0;
            seg_digits_q <= '0;
        end else begin
            if (sample) indata_q <= indata;
            error_q <= error_d;
            done_q  <= (state_q == S_DONE);
            case (state_q)
                S_IDLE: if (result_valid) begin
                    sign_q <= result[WIDTH-1];
                    // Unsigned view makes the most-negative value come out as 2^(WIDTH-1)
                    mag_q  <= result[WIDTH-1] ? -result : result;
                    bcd_q  <= '0;
                    cnt_q  <= '0;
                end
                S_SHIFT: begin
                    bcd_q <= bcd_shift;
                    mag_q <= {mag_q[WIDTH-2:0], 1'b0};
                    cnt_q <= cnt_q + 1'b1;
                end
                S_DONE: begin
                    seg_sign_q   <= disp_sign;
                    seg_digits_q <= disp;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_io_display_unit.sv
// Self-checking bench for io_display_unit: vector table of conversions scored through a queue,
// plus hand sequences for error flag, ignored requests while busy and reset mid-conversion.
module tb_io_display_unit;

    localparam int N_IN = 7, WIDTH = 8, DIGITS = 3;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [N_IN*WIDTH-1:0] indata;
    logic                  sample;
    logic [N_IN*WIDTH-1:0] indata_q;
    logic [WIDTH-1:0]      result;
    logic                  result_valid, overflow_in, stack_error_in, error_clear;
    logic                  busy, done, error;
    logic [3:0]            seg_sign;
    logic [4*DIGITS-1:0]   seg_digits;

    io_display_unit #(.N_IN(N_IN), .WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk(clk), .reset(reset), .indata(indata), .sample(sample), .indata_q(indata_q),
        .result(result), .result_valid(result_valid), .overflow_in(overflow_in),
        .stack_error_in(stack_error_in), .error_clear(error_clear), .busy(busy), .done(done),
        .error(error), .seg_sign(seg_sign), .seg_digits(seg_digits)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  r;
        logic [3:0]  s;
        logic [11:0] d;
    } vec_t;

    vec_t expq[$];
    vec_t tbl[11];
    int nvec = 0, nerr = 0, ndone = 0;
    logic [11:0] last_d = 12'h000;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Turn a plain sign/digit expectation into its blanked form when blanking is built in
    function automatic vec_t mk(input logic [7:0] r, input logic [3:0] s, input logic [11:0] d);
        vec_t v;
        v.r = r; v.s = s; v.d = d;
`ifdef IO_DISPLAY_BLANK_EN
        if (s == 4'h0) v.s = 4'hA;
        if (d[11:8] == 4'h0) begin
            v.d[11:8] = 4'hA;
            if (d[7:4] == 4'h0) v.d[7:4] = 4'hA;
        end
`endif
        return v;
    endfunction

    always @(negedge clk) begin
        if (!reset && done) begin
            vec_t e;
            ndone++;
            if (expq.size() == 0) begin
                nvec++; nerr++;
                $display("FAIL unexpected_done: got done=1, required no pending conversion");
            end else begin
                e = expq.pop_front();
                chk($sformatf("seg_sign[%0h]", e.r), seg_sign, e.s);
                chk($sformatf("seg_digits[%0h]", e.r), seg_digits, e.d);
            end
        end
    end

    task automatic convert(input vec_t v);
        int cnt;
        @(negedge clk);
        result = v.r; result_valid = 1'b1;
        expq.push_back(v);
        @(negedge clk);
        result_valid = 1'b0;
        cnt = 0;
        while (busy && cnt < 40) begin
            cnt++;
            if (cnt == 5) chk("display_hold", seg_digits, last_d);
            @(negedge clk);
        end
        chk("busy_cycles", cnt, 9);
        chk("done_at_end", done, 1);
        last_d = v.d;
        @(negedge clk);
        chk("done_one_cycle", done, 0);
    endtask

    initial begin
        int cnt, d0;
        tbl[0]  = mk(8'd123, 4'h0, 12'h123);
        tbl[1]  = mk(8'h80,  4'hF, 12'h128);
        tbl[2]  = mk(8'hFF,  4'hF, 12'h001);
        tbl[3]  = mk(8'h00,  4'h0, 12'h000);
        tbl[4]  = mk(8'd127, 4'h0, 12'h127);
        tbl[5]  = mk(8'h81,  4'hF, 12'h127);
        tbl[6]  = mk(8'd100, 4'h0, 12'h100);
        tbl[7]  = mk(8'd10,  4'h0, 12'h010);
        tbl[8]  = mk(8'hF6,  4'hF, 12'h010);
        tbl[9]  = mk(8'd9,   4'h0, 12'h009);
        tbl[10] = mk(8'd59,  4'h0, 12'h059);

        reset = 1'b1; indata = '0; sample = 1'b0; result = '0; result_valid = 1'b0;
        overflow_in = 1'b0; stack_error_in = 1'b0; error_clear = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_indata_q", indata_q, 0);
        chk("rst_seg_sign", seg_sign, 4'h0);
        chk("rst_seg_digits", seg_digits, 12'h000);
        reset = 1'b0;

        foreach (tbl[i]) convert(tbl[i]);

        // Error flag: sign bit of a sampled channel, stickiness, set-beats-clear
        @(negedge clk);
        indata = '0; indata[3*WIDTH +: WIDTH] = 8'h85; sample = 1'b1;
        @(negedge clk);
        sample = 1'b0;
        chk("snapshot", indata_q[3*WIDTH +: WIDTH], 8'h85);
        chk("err_not_yet", error, 0);
        @(negedge clk);
        chk("err_set", error, 1);
        indata[3*WIDTH +: WIDTH] = 8'h05; sample = 1'b1;
        @(negedge clk);
        sample = 1'b0; indata = '1;
        repeat (2) @(negedge clk);
        chk("snapshot_hold", indata_q[3*WIDTH +: WIDTH], 8'h05);
        chk("err_sticky", error, 1);
        stack_error_in = 1'b1; error_clear = 1'b1;
        @(negedge clk);
        stack_error_in = 1'b0; error_clear = 1'b0;
        @(negedge clk);
        chk("err_set_wins", error, 1);
        error_clear = 1'b1;
        @(negedge clk);
        error_clear = 1'b0;
        chk("err_cleared", error, 0);
        overflow_in = 1'b1;
        @(negedge clk);
        overflow_in = 1'b0;
        @(negedge clk);
        chk("err_overflow", error, 1);
        error_clear = 1'b1;
        @(negedge clk);
        error_clear = 1'b0;
        chk("err_cleared2", error, 0);

        // A request arriving mid-conversion is dropped
        d0 = ndone;
        @(negedge clk);
        result = 8'd99; result_valid = 1'b1;
        expq.push_back(mk(8'd99, 4'h0, 12'h099));
        @(negedge clk);
        result_valid = 1'b0;
        repeat (2) @(negedge clk);
        result = 8'd45; result_valid = 1'b1;
        @(negedge clk);
        result_valid = 1'b0;
        cnt = 0;
        while (busy && cnt < 40) begin cnt++; @(negedge clk); end
        chk("collide_busy", cnt, 6);
        repeat (15) @(negedge clk);
        chk("collide_single_done", ndone - d0, 1);
        chk("collide_idle", busy, 0);

        // Reset mid-conversion, asserted together with every other input activity
        d0 = ndone;
        @(negedge clk);
        result = 8'd77; result_valid = 1'b1;
        @(negedge clk);
        result_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1; sample = 1'b1; indata = '1; overflow_in = 1'b1; result_valid = 1'b1;
        @(negedge clk);
        reset = 1'b0; sample = 1'b0; overflow_in = 1'b0; result_valid = 1'b0; indata = '0;
        chk("abort_busy", busy, 0);
        chk("abort_digits", seg_digits, 12'h000);
        chk("abort_sign", seg_sign, 4'h0);
        chk("abort_indata_q", indata_q, 0);
        chk("abort_error", error, 0);
        repeat (15) @(negedge clk);
        chk("abort_no_done", ndone - d0, 0);
        last_d = 12'h000;

        convert(mk(8'd45, 4'h0, 12'h045));
        chk("queue_drained", expq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
